cam_frame_capture: RTL and testbench

- Parametrised camera capture engine in the camera pixel-clock domain; successor to the fixed single-format capture logic in the camera/VGA top.
- Takes the 8-bit DVP stream from the sensor (vsync/href/data), pairs bytes into pixels, and emits one write per pixel into the frame buffer.
- Adds RGB444/RGB565 format selection, 2x decimation, single-shot and continuous modes, abort, a frame counter and sticky error flags.
- Register-block fields drive the control inputs through the top level.

---
 rtl/cam_frame_capture.sv | 229 ++++++++++++++++++++++
 tb/tb_cam_frame_capture.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_capture.sv
// DVP camera capture engine: pairs sensor bytes into pixels and writes them to a frame
// buffer, with RGB444/RGB565 formatting, 2x decimation, single/continuous modes and sticky errors.
module cam_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 12,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              continuous,
  input  logic              fmt,
  input  logic              decim_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_line,
  output logic              err_ovf
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // One spare bit so the next-address counter can sit at the limit without wrapping.
  typedef logic [ADDR_W:0]  addr_ext_t;
  typedef logic [PIX_W-1:0] pix_t;

  localparam addr_ext_t   LIM_FULL = addr_ext_t'(H_ACTIVE * V_ACTIVE);
  localparam addr_ext_t   LIM_DEC  = addr_ext_t'((H_ACTIVE * V_ACTIVE) / 4);
  localparam logic [15:0] H_LIM    = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM    = 16'(V_ACTIVE);

  function automatic pix_t fmt_pixel(input logic fmt_565, input logic [7:0] b0,
                                     input logic [7:0] b1);
    pix_t p;
    if (!fmt_565) begin
      p = pix_t'({b0[3:0], b1});
    end else if (PIX_W == 16) begin
      p = pix_t'({b0, b1});
    end else begin
      p = pix_t'({b0[7:4], b0[2:0], b1[7], b1[4:1]});
    end
    return p;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic              vs_prev_q, href_prev_q;
  logic              phase_q, phase_d;
  logic [7:0]        b0_q, b0_d;
  logic [15:0]       col_q, col_d;
  logic [15:0]       line_q, line_d;
  addr_ext_t         addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  pix_t              wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              err_line_q, err_line_d;
  logic              err_ovf_q, err_ovf_d;

  logic      vsync_fall_s, vsync_rise_s, href_fall_s, keep_s;
  addr_ext_t lim_s;
  pix_t      pix_s;

  assign vsync_fall_s = vs_prev_q & ~cam_vsync;
  assign vsync_rise_s = ~vs_prev_q & cam_vsync;
  assign href_fall_s  = href_prev_q & ~cam_href;
  assign lim_s        = decim_en ? LIM_DEC : LIM_FULL;
  assign keep_s       = ~decim_en | (~col_q[0] & ~line_q[0]);
  assign pix_s        = fmt_pixel(fmt, b0_q, cam_data);

  // Next-state, pixel assembly, write generation and error tracking.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    b0_d          = b0_q;
    col_d         = col_q;
    line_d        = line_q;
    addr_d        = addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    err_line_d    = err_line_q;
    err_ovf_d     = err_ovf_q;

    case (state_q)
      S_IDLE: begin
        if (arm && !abort) begin
          state_d    = S_WAIT_VS;
          err_line_d = 1'b0;
          err_ovf_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_VS: begin
        if (vsync_fall_s) begin
          state_d = S_CAPTURE;
          addr_d  = addr_ext_t'(0);
          line_d  = 16'd0;
          col_d   = 16'd0;
          phase_d = 1'b0;
        end else begin
          state_d = S_WAIT_VS;
        end
      end
      S_CAPTURE: begin
        if (vsync_rise_s) begin
          state_d    = S_DONE;
          err_line_d = err_line_q | (line_q != V_LIM);
        end else begin
          state_d = S_CAPTURE;
        end
        if (cam_href) begin
          if (!phase_q) begin
            b0_d    = cam_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            col_d   = sat_inc(col_q);
            // Pixels past the last line or the buffer end are dropped and flagged.
            if (line_q >= V_LIM) begin
              err_ovf_d = 1'b1;
            end else if (keep_s) begin
              if (addr_q >= lim_s) begin
                err_ovf_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q[ADDR_W-1:0];
                wr_data_d = pix_s;
                addr_d    = addr_q + addr_ext_t'(1);
              end
            end else begin
              err_ovf_d = err_ovf_q;
            end
          end
        end else begin
          phase_d = 1'b0;
          if (href_fall_s) begin
            err_line_d = err_line_d | (col_q != H_LIM) | phase_q;
            line_d     = sat_inc(line_q);
            col_d      = 16'd0;
          end else begin
            line_d = line_q;
          end
        end
      end
      S_DONE: begin
        state_d = continuous ? S_WAIT_VS : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition and kills the write that would follow.
    state_d       = abort ? S_IDLE : state_d;
    wr_en_d       = wr_en_d & ~abort;
    frame_done_d  = (state_d == S_DONE);
    frame_count_d = frame_done_d ? frame_count_q + 16'd1 : frame_count_q;
    busy_d        = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      vs_prev_q     <= 1'b0;
      href_prev_q   <= 1'b0;
      phase_q       <= 1'b0;
      b0_q          <= 8'd0;
      col_q         <= 16'd0;
      line_q        <= 16'd0;
      addr_q        <= addr_ext_t'(0);
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      err_line_q    <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_prev_q     <= cam_vsync;
      href_prev_q   <= cam_href;
      phase_q       <= phase_d;
      b0_q          <= b0_d;
      col_q         <= col_d;
      line_q        <= line_d;
      addr_q        <= addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_line_q    <= err_line_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_line    = err_line_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture: two instances (4x2 RGB12 and 4x4 RGB16) share one DVP stream
// and are scored against a per-pixel reference model of the capture rules.
module tb_cam_frame_capture;

  localparam int HA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, cam_vsync, cam_href, arm, abort, continuous, fmt, decim_en;
  logic [7:0] cam_data;

  logic        wr_en_a, busy_a, frame_done_a, err_line_a, err_ovf_a;
  logic [2:0]  wr_addr_a;
  logic [11:0] wr_data_a;
  logic [15:0] frame_count_a;
  logic        wr_en_b, busy_b, frame_done_b, err_line_b, err_ovf_b;
  logic [3:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic [15:0] frame_count_b;

  cam_frame_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .PIX_W(12), .ADDR_W(3)) dut_a (
    .clk(clk), .rstn(rstn), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .arm(arm), .abort(abort), .continuous(continuous), .fmt(fmt), .decim_en(decim_en),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a),
    .frame_done(frame_done_a), .frame_count(frame_count_a), .err_line(err_line_a),
    .err_ovf(err_ovf_a));

  cam_frame_capture #(.H_ACTIVE(4), .V_ACTIVE(4), .PIX_W(16), .ADDR_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .arm(arm), .abort(abort), .continuous(continuous), .fmt(fmt), .decim_en(decim_en),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_count(frame_count_b), .err_line(err_line_b),
    .err_ovf(err_ovf_b));

  // Observed writes as addr*65536+data, and frame_done pulse counts, per instance.
  int got_q[2][$];
  int fd_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en_a) got_q[0].push_back(int'(wr_addr_a) * 65536 + int'(wr_data_a));
      if (wr_en_b) got_q[1].push_back(int'(wr_addr_b) * 65536 + int'(wr_data_b));
      if (frame_done_a) fd_cnt[0]++;
      if (frame_done_b) fd_cnt[1]++;
    end
  end

  typedef enum int {M_IDLE, M_WAIT, M_CAP} mstate_t;
  mstate_t mst;
  int m_line, m_frames;
  int m_addr[2];
  bit m_eline[2], m_eovf[2];
  int exp_q[2][$];
  int rd_q[2];
  int fd_ref[2];
  int n_pass = 0, n_total = 0;
  int blen[6] = '{8, 8, 8, 6, 7, 10};

  function automatic int v_of(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int pw_of(int d);
    return (d == 0) ? 12 : 16;
  endfunction

  function automatic int model_px(bit f, int pw, int b0, int b1);
    if (!f) return (b0 % 16) * 256 + b1;
    if (pw == 16) return b0 * 256 + b1;
    return (b0 / 16) * 256 + (b0 % 8) * 32 + (b1 / 128) * 16 + (b1 / 2) % 16;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mst = M_IDLE; m_line = 0; m_frames = 0;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 0; m_eline[d] = 1'b0; m_eovf[d] = 1'b0;
      exp_q[d].delete();
      rd_q[d] = got_q[d].size();
      fd_ref[d] = fd_cnt[d];
    end
  endtask

  task automatic model_pixel(input int col, input int b0, input int b1);
    for (int d = 0; d < 2; d++) begin
      int lim;
      lim = HA * v_of(d) / (decim_en ? 4 : 1);
      if (m_line >= v_of(d)) m_eovf[d] = 1'b1;
      else if (decim_en && ((col % 2) != 0 || (m_line % 2) != 0)) m_eovf[d] = m_eovf[d];
      else if (m_addr[d] >= lim) m_eovf[d] = 1'b1;
      else begin
        exp_q[d].push_back(m_addr[d] * 65536 + model_px(fmt, pw_of(d), b0, b1));
        m_addr[d]++;
      end
    end
  endtask

  task automatic drive_line(input int nbytes, input int abort_at, input bit rnd,
                            input int fb0, input int fb1);
    int b0 = 0;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      cam_href = 1'b1;
      cam_data = rnd ? 8'($urandom_range(0, 255)) : 8'(((i % 2) != 0) ? fb1 : fb0);
      abort = (i == abort_at);
      if (i == abort_at) mst = M_IDLE;
      if (mst == M_CAP) begin
        if ((i % 2) == 0) b0 = int'(cam_data);
        else model_pixel(i / 2, b0, int'(cam_data));
      end
    end
    @(posedge clk); #1;
    cam_href = 1'b0; abort = 1'b0;
    if (mst == M_CAP) begin
      if (nbytes != 2 * HA) begin m_eline[0] = 1'b1; m_eline[1] = 1'b1; end
      m_line++;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1;
    cam_vsync = 1'b1;
    if (mst == M_CAP) begin
      for (int d = 0; d < 2; d++) if (m_line != v_of(d)) m_eline[d] = 1'b1;
      m_frames++;
      mst = continuous ? M_WAIT : M_IDLE;
    end
    repeat (3) @(posedge clk); #1;
    cam_vsync = 1'b0;
    if (mst == M_WAIT) begin
      mst = M_CAP; m_line = 0; m_addr[0] = 0; m_addr[1] = 0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_arm(input bit with_abort);
    @(posedge clk); #1;
    arm = 1'b1; abort = with_abort;
    if (with_abort) mst = M_IDLE;
    else if (mst == M_IDLE) begin
      mst = M_WAIT; m_eline[0] = 1'b0; m_eline[1] = 1'b0; m_eovf[0] = 1'b0; m_eovf[1] = 1'b0;
    end
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en_a | wr_en_b), 32'd0);
    chk({tag, ".wr_addr"}, 32'(wr_addr_a) | 32'(wr_addr_b), 32'd0);
    chk({tag, ".wr_data"}, 32'(wr_data_a) | 32'(wr_data_b), 32'd0);
    chk({tag, ".busy"}, 32'(busy_a | busy_b), 32'd0);
    chk({tag, ".frame_done"}, 32'(frame_done_a | frame_done_b), 32'd0);
    chk({tag, ".frame_count"}, 32'(frame_count_a) | 32'(frame_count_b), 32'd0);
    chk({tag, ".errs"}, 32'({err_line_a, err_ovf_a, err_line_b, err_ovf_b}), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    int ng;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ng = got_q[d].size() - rd_q[d];
      chk($sformatf("%s.nwr%0d", tag, d), 32'(ng), 32'(exp_q[d].size()));
      for (int i = 0; i < exp_q[d].size() && i < ng; i++)
        chk($sformatf("%s.wr%0d_%0d", tag, d, i), 32'(got_q[d][rd_q[d] + i]), 32'(exp_q[d][i]));
      rd_q[d] = got_q[d].size();
      exp_q[d].delete();
      chk($sformatf("%s.err_line%0d", tag, d), (d == 0) ? 32'(err_line_a) : 32'(err_line_b),
          32'(m_eline[d]));
      chk($sformatf("%s.err_ovf%0d", tag, d), (d == 0) ? 32'(err_ovf_a) : 32'(err_ovf_b),
          32'(m_eovf[d]));
      chk($sformatf("%s.fcount%0d", tag, d), (d == 0) ? 32'(frame_count_a) : 32'(frame_count_b),
          32'(m_frames % 65536));
      chk($sformatf("%s.fdone%0d", tag, d), 32'(fd_cnt[d] - fd_ref[d]), 32'(m_frames));
      chk($sformatf("%s.busy%0d", tag, d), (d == 0) ? 32'(busy_a) : 32'(busy_b),
          32'(mst != M_IDLE));
    end
  endtask

  initial begin
    rstn = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
    arm = 1'b0; abort = 1'b0; continuous = 1'b0; fmt = 1'b0; decim_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_zero("reset");

    // Single RGB444 frame of 0x0A/0xBC pairs.
    do_arm(1'b0);
    vsync_pulse();
    repeat (2) drive_line(8, -1, 1'b0, 8'h0A, 8'hBC);
    vsync_pulse();
    check_frame("rgb444");

    fmt = 1'b1;
    do_arm(1'b0);
    vsync_pulse();
    repeat (2) drive_line(8, -1, 1'b0, 8'hF8, 8'h1F);
    vsync_pulse();
    check_frame("rgb565");
    fmt = 1'b0;

    decim_en = 1'b1;
    do_arm(1'b0);
    vsync_pulse();
    repeat (4) drive_line(8, -1, 1'b1, 0, 0);
    vsync_pulse();
    check_frame("decim");
    decim_en = 1'b0;

    // Arm mid-frame: the rest of that frame must be skipped; then a 3-pixel line.
    drive_line(8, -1, 1'b1, 0, 0);
    do_arm(1'b0);
    drive_line(8, -1, 1'b1, 0, 0);
    vsync_pulse();
    drive_line(6, -1, 1'b1, 0, 0);
    drive_line(8, -1, 1'b1, 0, 0);
    vsync_pulse();
    check_frame("midarm");

    do_arm(1'b0);
    vsync_pulse();
    drive_line(8, -1, 1'b1, 0, 0);
    drive_line(10, -1, 1'b1, 0, 0);
    vsync_pulse();
    check_frame("ovf");
    chk("ovf.addr_hold", 32'(wr_addr_a), 32'd7);

    do_reset();
    continuous = 1'b1;
    do_arm(1'b0);
    vsync_pulse();
    for (int f = 0; f < 3; f++) begin
      repeat (2) drive_line(8, -1, 1'b1, 0, 0);
      vsync_pulse();
      check_frame($sformatf("cont%0d", f));
    end
    drive_line(8, 5, 1'b1, 0, 0);
    check_frame("abort");
    continuous = 1'b0;
    vsync_pulse();
    check_frame("abort_nofd");

    do_arm(1'b1);
    @(negedge clk);
    chk("armabort.busy", 32'(busy_a), 32'd0);
    vsync_pulse();
    drive_line(8, -1, 1'b1, 0, 0);
    vsync_pulse();
    check_frame("armabort");

    for (int r = 0; r < 5; r++) begin
      int nl;
      fmt = 1'($urandom_range(0, 1));
      decim_en = 1'($urandom_range(0, 1));
      nl = $urandom_range(1, 5);
      do_arm(1'b0);
      vsync_pulse();
      for (int l = 0; l < nl; l++) drive_line(blen[$urandom_range(0, 5)], -1, 1'b1, 0, 0);
      vsync_pulse();
      check_frame($sformatf("rand%0d", r));
    end
    fmt = 1'b0; decim_en = 1'b0;

    // Reset while a write strobe is already out.
    do_arm(1'b0);
    vsync_pulse();
    @(posedge clk); #1;
    cam_href = 1'b1; cam_data = 8'h12;
    @(posedge clk); #1;
    cam_data = 8'h34;
    @(posedge clk); #1;
    chk("rstcap.pre_wr", 32'(wr_en_a), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check_zero("rstcap");
    cam_href = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rstcap.idle", 32'(busy_a | busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
